// File: rtl/rot_stim_gen.sv
// Rotary-encoder stimulus generator: turns rotate/press/hold commands into quadrature,
// push-button waveforms with optional programmable contact bounce.
module rot_stim_gen #(
    parameter int PHASE_TICKS  = 4,
    parameter int BOUNCE_TICKS = 0,
    parameter int PRESS_TICKS  = 16,
    parameter int STEP_W       = 8
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              ROT_A,
    output logic              ROT_B,
    output logic              ROT_CENTER,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    localparam int MAXT = (PHASE_TICKS > PRESS_TICKS) ? PHASE_TICKS : PRESS_TICKS;
    localparam int TW   = $clog2(MAXT + 1);
    localparam logic [TW-1:0] PH_LAST = TW'(PHASE_TICKS - 1);
    localparam logic [TW-1:0] PR_LAST = TW'(PRESS_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_PRESS, S_HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [TW-1:0]     r_tick, w_tick_nxt;
    logic [1:0]        r_ph, w_ph_nxt;
    logic [STEP_W-1:0] r_cnt, w_cnt_nxt;
    logic [STEP_W-1:0] r_sd, w_sd_nxt;
    logic [STEP_W-1:0] r_len, w_len_nxt;
    logic              r_left, w_left_nxt;
    logic              r_a, r_b, r_c, r_ready, r_done;
    logic              w_accept, w_a_nxt, w_b_nxt, w_c_nxt;

    // Within the first 2*BOUNCE_TICKS cycles of an edge, odd cycles fall back to the old level.
    function automatic logic bounce_old(input logic [TW-1:0] k);
        return (int'(k) < 2 * BOUNCE_TICKS) && k[0];
    endfunction

    function automatic logic [1:0] ab_new(input logic left, input logic [1:0] ph);
        case (ph)
            2'd0:    return left ? 2'b01 : 2'b10;
            2'd1:    return 2'b11;
            2'd2:    return left ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Old level of phase 0 is the level reached at the end of phase 3 (rest).
    function automatic logic [1:0] ab_at(input logic left, input logic [1:0] ph,
                                         input logic [TW-1:0] k);
        return bounce_old(k) ? ab_new(left, ph - 2'd1) : ab_new(left, ph);
    endfunction

    function automatic logic press_at(input logic falling, input logic [TW-1:0] k);
        return bounce_old(k) ? falling : ~falling;
    endfunction

    assign w_accept = cmd_valid && (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_ph_nxt    = r_ph;
        w_cnt_nxt   = r_cnt;
        w_sd_nxt    = r_sd;
        w_len_nxt   = r_len;
        w_left_nxt  = r_left;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_tick_nxt = '0;
                    w_ph_nxt   = 2'd0;
                    w_cnt_nxt  = '0;
                    w_len_nxt  = cmd_steps;
                    w_left_nxt = cmd_op[0];
                    case (cmd_op)
                        2'b10:   w_state_nxt = S_PRESS;
                        2'b11:   w_state_nxt = S_HOLD;
                        default: begin
                            w_state_nxt = S_ROT;
                            w_sd_nxt    = '0;
                        end
                    endcase
                end
            end
            S_ROT: begin
                if (r_len == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tick == PH_LAST) begin
                    w_tick_nxt = '0;
                    w_ph_nxt   = r_ph + 2'd1;
                    if (r_ph == 2'd3) begin
                        w_sd_nxt = r_sd + STEP_W'(1);
                        if (r_sd + STEP_W'(1) == r_len) w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
            end
            S_HOLD: begin
                if (r_len == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tick == PH_LAST) begin
                    w_tick_nxt = '0;
                    w_cnt_nxt  = r_cnt + STEP_W'(1);
                    if (r_cnt + STEP_W'(1) == r_len) w_state_nxt = S_IDLE;
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
            end
            default: begin
                // Press: ph[0] selects the rising (0) or falling (1) half.
                if (r_tick == PR_LAST) begin
                    w_tick_nxt = '0;
                    w_ph_nxt   = r_ph + 2'd1;
                    if (r_ph[0]) w_state_nxt = S_IDLE;
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
            end
        endcase

        // Outputs are computed for the cycle the next-state values describe, then registered.
        w_a_nxt = 1'b0;
        w_b_nxt = 1'b0;
        w_c_nxt = 1'b0;
        if (w_state_nxt == S_ROT && w_len_nxt != '0)
            {w_a_nxt, w_b_nxt} = ab_at(w_left_nxt, w_ph_nxt, w_tick_nxt);
        if (w_state_nxt == S_PRESS)
            w_c_nxt = press_at(w_ph_nxt[0], w_tick_nxt);
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_ph    <= 2'd0;
            r_cnt   <= '0;
            r_sd    <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_c     <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_ph    <= w_ph_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sd    <= w_sd_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
        end
    end

    // Command operands only matter once a command is accepted, so they carry no reset.
    always_ff @(posedge CLK50MHZ) begin
        r_len  <= w_len_nxt;
        r_left <= w_left_nxt;
    end

    assign ROT_A      = r_a;
    assign ROT_B      = r_b;
    assign ROT_CENTER = r_c;
    assign cmd_ready  = r_ready;
    assign done       = r_done;
    assign steps_done = r_sd;

endmodule
